// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 3x4 keypad row scan, ghost rejection, debounce, 0-9 decode, valid/ready output
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
   parameter int SCAN_DIV   = 4,
   parameter int DEBOUNCE   = 3,
   parameter int REPEAT_DLY = 8
) (
   input  logic       i_clk,
   input  logic       i_reset,
   output logic [3:0] o_row,
   input  logic [2:0] i_col,
   output logic       o_key_valid,
   output logic [3:0] o_key_number,
   input  logic       i_key_ready,
   output logic       o_overrun
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int SW = $clog2(DEBOUNCE + 1);
   localparam logic [3:0] NONE = 4'hF;

   generate
      if (SCAN_DIV < 2 || DEBOUNCE < 1 || REPEAT_DLY < 1) begin : g_param_check
         $error("keypad_scanner: illegal parameter value");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

   logic [DW-1:0] r_dwell;
   logic [3:0]    r_row;
   logic [1:0]    r_cnt;
   logic [3:0]    r_acc;
   logic [3:0]    r_prev;
   logic [SW-1:0] r_stable;
   state_t        r_state;
   logic [3:0]    r_key;
   logic          r_emit;
   logic [3:0]    r_emit_key;
   logic          r_valid;
   logic [3:0]    r_number;
   logic          r_overrun;

   logic          w_sample;
   logic          w_scan_end;
   logic [1:0]    w_row_cnt;
   logic [3:0]    w_row_key;
   logic [2:0]    w_total;
   logic [1:0]    w_cnt_nxt;
   logic [3:0]    w_key_nxt;
   logic [3:0]    w_cand;
   logic [SW-1:0] w_stable_nxt;
   state_t        w_state_nxt;
   logic          w_emit;
   logic [3:0]    w_emit_key;
   logic          w_hold;
   logic          w_consume;

   assign w_sample   = (r_dwell == DW'(SCAN_DIV - 1));
   assign w_scan_end = w_sample & r_row[3];

   // Row g only has a real contact on column b; g&a and g&c are not keys.
   always_comb begin
      w_row_cnt = 2'd0;
      w_row_key = 4'd0;
      if (r_row[3]) begin
         w_row_cnt = {1'b0, i_col[1]};
      end else begin
         w_row_cnt = {1'b0, i_col[0]} + {1'b0, i_col[1]} + {1'b0, i_col[2]};
         w_row_key = (r_row[0] ? 4'd0 : r_row[1] ? 4'd3 : 4'd6)
                   + (i_col[0] ? 4'd1 : i_col[1] ? 4'd2 : 4'd3);
      end
   end

   assign w_total   = {1'b0, r_cnt} + {1'b0, w_row_cnt};
   assign w_cnt_nxt = (w_total >= 3'd2) ? 2'd2 : w_total[1:0];
   assign w_key_nxt = (r_cnt == 2'd0) ? w_row_key : r_acc;
   assign w_cand    = (w_cnt_nxt == 2'd1) ? w_key_nxt : NONE;

   assign w_stable_nxt = (w_cand != r_prev)             ? SW'(1) :
                         (r_stable == SW'(DEBOUNCE))    ? r_stable :
                                                          r_stable + SW'(1);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_dwell  <= '0;
         r_row    <= 4'b0001;
         r_cnt    <= 2'd0;
         r_acc    <= 4'd0;
         r_prev   <= NONE;
         r_stable <= '0;
      end else if (w_sample) begin
         r_dwell <= '0;
         r_row   <= {r_row[2:0], r_row[3]};
         if (r_row[3]) begin
            r_cnt    <= 2'd0;
            r_acc    <= 4'd0;
            r_prev   <= w_cand;
            r_stable <= w_stable_nxt;
         end else begin
            r_cnt <= w_cnt_nxt;
            r_acc <= w_key_nxt;
         end
      end else begin
         r_dwell <= r_dwell + DW'(1);
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_DLY + 1);
   logic [RW-1:0] r_rep;
   logic          w_rep_inc;
   logic          w_rep_clr;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_emit_key  = w_cand;
      w_hold      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      w_rep_inc   = 1'b0;
      w_rep_clr   = 1'b0;
`endif
      if (w_scan_end) begin
         case (r_state)
            S_IDLE, S_DEBOUNCE: begin
               if (w_cand == NONE) begin
                  w_state_nxt = S_IDLE;
               end else if (w_stable_nxt == SW'(DEBOUNCE)) begin
                  w_emit      = 1'b1;
                  w_hold      = 1'b1;
                  w_state_nxt = S_HELD;
               end else begin
                  w_state_nxt = S_DEBOUNCE;
               end
            end
            S_HELD: begin
               if (w_cand != r_key) begin
                  w_state_nxt = S_RELEASE;
               end
`ifdef KEYPAD_AUTOREPEAT_EN
               else if (r_rep == RW'(REPEAT_DLY - 1)) begin
                  w_emit     = 1'b1;
                  w_emit_key = r_key;
                  w_rep_clr  = 1'b1;
               end else begin
                  w_rep_inc = 1'b1;
               end
`endif
            end
            S_RELEASE: begin
               if (w_cand == NONE && w_stable_nxt == SW'(DEBOUNCE)) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_key      <= 4'd0;
         r_emit     <= 1'b0;
         r_emit_key <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_emit     <= w_emit;
         r_emit_key <= w_emit_key;
         if (w_hold) begin
            r_key <= w_emit_key;
         end
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rep <= '0;
      end else if (w_hold || w_rep_clr) begin
         r_rep <= '0;
      end else if (w_rep_inc) begin
         r_rep <= r_rep + RW'(1);
      end
   end
`endif

   assign w_consume = r_valid & i_key_ready;

   // A key consumed on this edge frees the register for an emit on the same edge.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_valid   <= 1'b0;
         r_number  <= 4'd0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (r_emit) begin
            if (!r_valid || w_consume) begin
               r_valid  <= 1'b1;
               r_number <= r_emit_key;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (w_consume) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_row        = r_row;
   assign o_key_valid  = r_valid;
   assign o_key_number = r_number;
   assign o_overrun    = r_overrun;

endmodule
